// File: rtl/decode_stage.sv
// decode_stage: MIPS-style decode slot with branch/jump resolution,
// delay-slot tracking and load-use hazard detection.
// Ports:
//   clk, resetn (sync, active-low), de_en, stall, flush
//   fe_pc, inst_sram_rdata      : fetch-side PC and instruction
//   rs_value, rt_value          : forwarded register operands
//   ex_is_load, ex_dest         : execute-stage load info
//   rs_addr, rt_addr            : register-file read addresses
//   de_valid, de_pc, de_inst    : decode slot state
//   de_in_delay_slot            : slot holds a delay-slot instruction
//   de_br_taken, de_stall_req   : branch taken / load-use hazard
//   nextpc                      : next fetch PC
module decode_stage #(
  parameter logic [31:0] RESET_PC = 32'hbfc00000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        de_en,
  input  logic        stall,
  input  logic        flush,
  input  logic [31:0] fe_pc,
  input  logic [31:0] inst_sram_rdata,
  input  logic [31:0] rs_value,
  input  logic [31:0] rt_value,
  input  logic        ex_is_load,
  input  logic [4:0]  ex_dest,
  output logic [4:0]  rs_addr,
  output logic [4:0]  rt_addr,
  output logic        de_valid,
  output logic [31:0] de_pc,
  output logic [31:0] de_inst,
  output logic        de_in_delay_slot,
  output logic        de_br_taken,
  output logic        de_stall_req,
  output logic [31:0] nextpc
);

  logic [5:0]  op;
  logic [5:0]  funct;
  logic        is_beq, is_bne, is_blez, is_bgtz;
  logic        is_bltz, is_bgez, is_j, is_jal;
  logic        is_jr, is_jalr;
  logic        is_br, is_jmp, is_jreg;
  logic        is_ctl;
  logic        cond;
  logic [31:0] pc4;
  logic [31:0] br_off;
  logic [31:0] target;
  logic        adv;
  logic signed [31:0] rs_s;

  assign op      = de_inst[31:26];
  assign funct   = de_inst[5:0];
  assign rs_addr = de_inst[25:21];
  assign rt_addr = de_inst[20:16];
  assign rs_s    = rs_value;

  assign is_beq  = (op == 6'b000100);
  assign is_bne  = (op == 6'b000101);
  assign is_blez = (op == 6'b000110);
  assign is_bgtz = (op == 6'b000111);
  assign is_bltz = (op == 6'b000001) &&
                   (rt_addr == 5'b00000);
  assign is_bgez = (op == 6'b000001) &&
                   (rt_addr == 5'b00001);
  assign is_j    = (op == 6'b000010);
  assign is_jal  = (op == 6'b000011);
  assign is_jr   = (op == 6'b000000) &&
                   (funct == 6'b001000);
  assign is_jalr = (op == 6'b000000) &&
                   (funct == 6'b001001);

  assign is_br   = is_beq | is_bne | is_blez |
                   is_bgtz | is_bltz | is_bgez;
  assign is_jmp  = is_j | is_jal;
  assign is_jreg = is_jr | is_jalr;

  // Marks the next captured instruction as a delay slot,
  // independent of whether the transfer is taken.
  assign is_ctl = de_valid & (is_br | is_jmp | is_jreg);

  assign pc4    = de_pc + 32'd4;
  assign br_off = {{14{de_inst[15]}}, de_inst[15:0], 2'b00};

  always_comb begin
    cond   = 1'b0;
    target = pc4 + br_off;
    unique case (1'b1)
      is_beq:  cond = (rs_value == rt_value);
      is_bne:  cond = (rs_value != rt_value);
      is_blez: cond = (rs_s <= 32'sd0);
      is_bgtz: cond = (rs_s > 32'sd0);
      is_bltz: cond = (rs_s < 32'sd0);
      is_bgez: cond = (rs_s >= 32'sd0);
      is_jmp: begin
        cond   = 1'b1;
        target = {pc4[31:28], de_inst[25:0], 2'b00};
      end
      is_jreg: begin
        cond   = 1'b1;
        target = rs_value;
      end
      default: cond = 1'b0;
    endcase
  end

  assign de_stall_req = resetn & de_valid & ex_is_load &
                        (ex_dest != 5'd0) &
                        ((ex_dest == rs_addr) |
                         (ex_dest == rt_addr));

  assign de_br_taken = resetn & de_valid & ~de_stall_req &
                       ~flush & cond;

  assign nextpc = de_br_taken ? target : fe_pc + 32'd4;

  assign adv = de_en & ~stall & ~de_stall_req;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      de_valid         <= 1'b0;
      de_pc            <= RESET_PC;
      de_inst          <= 32'd0;
      de_in_delay_slot <= 1'b0;
    end else if (flush) begin
      de_valid         <= 1'b0;
      de_inst          <= 32'd0;
      de_in_delay_slot <= 1'b0;
    end else if (adv) begin
      de_valid         <= 1'b1;
      de_pc            <= fe_pc;
      de_inst          <= inst_sram_rdata;
      de_in_delay_slot <= is_ctl;
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed checks for decode_stage.
// Drives vectors after each rising edge and compares outputs.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        resetn;
  logic        de_en;
  logic        stall;
  logic        flush;
  logic [31:0] fe_pc;
  logic [31:0] inst_sram_rdata;
  logic [31:0] rs_value;
  logic [31:0] rt_value;
  logic        ex_is_load;
  logic [4:0]  ex_dest;
  logic [4:0]  rs_addr;
  logic [4:0]  rt_addr;
  logic        de_valid;
  logic [31:0] de_pc;
  logic [31:0] de_inst;
  logic        de_in_delay_slot;
  logic        de_br_taken;
  logic        de_stall_req;
  logic [31:0] nextpc;

  int errors = 0;
  int checks = 0;

  decode_stage dut (
    .clk(clk), .resetn(resetn), .de_en(de_en),
    .stall(stall), .flush(flush), .fe_pc(fe_pc),
    .inst_sram_rdata(inst_sram_rdata),
    .rs_value(rs_value), .rt_value(rt_value),
    .ex_is_load(ex_is_load), .ex_dest(ex_dest),
    .rs_addr(rs_addr), .rt_addr(rt_addr),
    .de_valid(de_valid), .de_pc(de_pc), .de_inst(de_inst),
    .de_in_delay_slot(de_in_delay_slot),
    .de_br_taken(de_br_taken), .de_stall_req(de_stall_req),
    .nextpc(nextpc)
  );

  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [31:0] pc,
                      input logic [31:0] inst);
    fe_pc = pc;
    inst_sram_rdata = inst;
    step();
  endtask

  task automatic test_reset;
    resetn = 1'b0; de_en = 1'b1; stall = 1'b0; flush = 1'b0;
    fe_pc = 32'h100; inst_sram_rdata = 32'h10220004;
    rs_value = 0; rt_value = 0; ex_is_load = 1'b1; ex_dest = 5'd1;
    step(); step();
    checks++; if (de_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got=%h exp=0", de_valid); end
    checks++; if (de_pc !== 32'hbfc00000) begin errors++; $display("FAIL rst_pc got=%h exp=bfc00000", de_pc); end
    checks++; if (de_inst !== 32'h0) begin errors++; $display("FAIL rst_inst got=%h exp=0", de_inst); end
    checks++; if (de_in_delay_slot !== 1'b0) begin errors++; $display("FAIL rst_dslot got=%h exp=0", de_in_delay_slot); end
    checks++; if (de_br_taken !== 1'b0) begin errors++; $display("FAIL rst_taken got=%h exp=0", de_br_taken); end
    checks++; if (de_stall_req !== 1'b0) begin errors++; $display("FAIL rst_stallreq got=%h exp=0", de_stall_req); end
    checks++; if (nextpc !== 32'h104) begin errors++; $display("FAIL rst_nextpc got=%h exp=00000104", nextpc); end
    ex_is_load = 1'b0; ex_dest = 5'd0;
  endtask

  task automatic test_first_fetch;
    resetn = 1'b1;
    load(32'hbfc00000, 32'h0);
    checks++; if (de_valid !== 1'b1) begin errors++; $display("FAIL ff_valid got=%h exp=1", de_valid); end
    checks++; if (de_pc !== 32'hbfc00000) begin errors++; $display("FAIL ff_pc got=%h exp=bfc00000", de_pc); end
    fe_pc = 32'hbfc00004; #1;
    checks++; if (nextpc !== 32'hbfc00008) begin errors++; $display("FAIL ff_nextpc got=%h exp=bfc00008", nextpc); end
    checks++; if (de_br_taken !== 1'b0) begin errors++; $display("FAIL ff_taken got=%h exp=0", de_br_taken); end
  endtask

  task automatic test_beq;
    load(32'hbfc00010, 32'h10220004);
    rs_value = 32'd5; rt_value = 32'd5;
    fe_pc = 32'hbfc00014; inst_sram_rdata = 32'h0; #1;
    checks++; if (de_br_taken !== 1'b1) begin errors++; $display("FAIL beq_taken got=%h exp=1", de_br_taken); end
    checks++; if (nextpc !== 32'hbfc00024) begin errors++; $display("FAIL beq_nextpc got=%h exp=bfc00024", nextpc); end
    checks++; if (de_in_delay_slot !== 1'b0) begin errors++; $display("FAIL beq_own_dslot got=%h exp=0", de_in_delay_slot); end
    step();
    checks++; if (de_in_delay_slot !== 1'b1) begin errors++; $display("FAIL beq_dslot got=%h exp=1", de_in_delay_slot); end
    checks++; if (de_pc !== 32'hbfc00014) begin errors++; $display("FAIL beq_dslot_pc got=%h exp=bfc00014", de_pc); end
  endtask

  task automatic test_bne;
    load(32'h1000, 32'h1464fffe);
    rs_value = 32'd7; rt_value = 32'd7;
    fe_pc = 32'h1004; inst_sram_rdata = 32'h0; #1;
    checks++; if (de_br_taken !== 1'b0) begin errors++; $display("FAIL bne_nt_taken got=%h exp=0", de_br_taken); end
    checks++; if (nextpc !== 32'h1008) begin errors++; $display("FAIL bne_nt_nextpc got=%h exp=00001008", nextpc); end
    rt_value = 32'd8; #1;
    checks++; if (nextpc !== 32'h00000ffc) begin errors++; $display("FAIL bne_back_nextpc got=%h exp=00000ffc", nextpc); end
    rt_value = 32'd7;
    step();
    checks++; if (de_in_delay_slot !== 1'b1) begin errors++; $display("FAIL bne_dslot got=%h exp=1", de_in_delay_slot); end
  endtask

  logic [31:0] cv_inst [14];
  logic [31:0] cv_rs   [14];
  logic        cv_exp  [14];
  logic        cv_ctl  [14];

  task automatic test_conditions;
    logic [31:0] exp_pc;
    cv_inst = '{32'h18A00010, 32'h18A00010, 32'h1CA00010, 32'h1CA00010,
                32'h04A00010, 32'h04A00010, 32'h04A10010, 32'h04A10010,
                32'h04A20010, 32'h24A00010, 32'h10A60010, 32'h10A60010,
                32'h14A60010, 32'h18A00010};
    cv_rs   = '{32'h0, 32'h1, 32'h1, 32'h80000000,
                32'hffffffff, 32'h0, 32'h0, 32'h80000000,
                32'hffffffff, 32'h0, 32'h2, 32'h3,
                32'h2, 32'hffffffff};
    cv_exp  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0,
                1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    cv_ctl  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1,
                1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    rt_value = 32'h2;
    for (int i = 0; i < 14; i++) begin
      load(32'h2000, cv_inst[i]);
      if (i > 0) begin
        checks++; if (de_in_delay_slot !== cv_ctl[i-1]) begin errors++; $display("FAIL cond_dslot[%0d] got=%h exp=%h", i, de_in_delay_slot, cv_ctl[i-1]); end
      end
      rs_value = cv_rs[i];
      fe_pc = 32'h2004; #1;
      exp_pc = cv_exp[i] ? 32'h2044 : 32'h2008;
      checks++; if (de_br_taken !== cv_exp[i]) begin errors++; $display("FAIL cond_taken[%0d] got=%h exp=%h", i, de_br_taken, cv_exp[i]); end
      checks++; if (nextpc !== exp_pc) begin errors++; $display("FAIL cond_nextpc[%0d] got=%h exp=%h", i, nextpc, exp_pc); end
    end
  endtask

  task automatic test_jumps;
    load(32'h2ffffffc, 32'h08123456);
    fe_pc = 32'h30000000; #1;
    checks++; if (nextpc !== 32'h3048d158) begin errors++; $display("FAIL j_nextpc got=%h exp=3048d158", nextpc); end
    load(32'h2ffffffc, 32'h0C123456);
    fe_pc = 32'h30000000; #1;
    checks++; if (nextpc !== 32'h3048d158) begin errors++; $display("FAIL jal_nextpc got=%h exp=3048d158", nextpc); end
    load(32'h500, 32'h0080F809);
    rs_value = 32'h12345678; fe_pc = 32'h504; #1;
    checks++; if (nextpc !== 32'h12345678) begin errors++; $display("FAIL jalr_nextpc got=%h exp=12345678", nextpc); end
    load(32'h504, 32'h01095021);
    checks++; if (de_in_delay_slot !== 1'b1) begin errors++; $display("FAIL jalr_dslot got=%h exp=1", de_in_delay_slot); end
    fe_pc = 32'h508; #1;
    checks++; if (de_br_taken !== 1'b0) begin errors++; $display("FAIL addu_taken got=%h exp=0", de_br_taken); end
  endtask

  task automatic test_jr_flush;
    load(32'h600, 32'h00800008);
    rs_value = 32'h80001000; fe_pc = 32'h604; #1;
    checks++; if (nextpc !== 32'h80001000) begin errors++; $display("FAIL jr_nextpc got=%h exp=80001000", nextpc); end
    flush = 1'b1; #1;
    checks++; if (de_br_taken !== 1'b0) begin errors++; $display("FAIL jr_flush_taken got=%h exp=0", de_br_taken); end
    checks++; if (nextpc !== 32'h608) begin errors++; $display("FAIL jr_flush_nextpc got=%h exp=00000608", nextpc); end
    step();
    flush = 1'b0;
    checks++; if (de_valid !== 1'b0) begin errors++; $display("FAIL flush_valid got=%h exp=0", de_valid); end
    checks++; if (de_inst !== 32'h0) begin errors++; $display("FAIL flush_inst got=%h exp=0", de_inst); end
    checks++; if (de_pc !== 32'h600) begin errors++; $display("FAIL flush_pc got=%h exp=00000600", de_pc); end
    load(32'h604, 32'h0);
    checks++; if (de_in_delay_slot !== 1'b0) begin errors++; $display("FAIL flush_next_dslot got=%h exp=0", de_in_delay_slot); end
  endtask

  task automatic test_load_use;
    load(32'h3000, 32'h01095021);
    ex_is_load = 1'b1; ex_dest = 5'd8;
    fe_pc = 32'h3004; inst_sram_rdata = 32'h11090003; #1;
    checks++; if (de_stall_req !== 1'b1) begin errors++; $display("FAIL lu_rs got=%h exp=1", de_stall_req); end
    step();
    checks++; if (de_pc !== 32'h3000) begin errors++; $display("FAIL lu_hold_pc got=%h exp=00003000", de_pc); end
    checks++; if (de_inst !== 32'h01095021) begin errors++; $display("FAIL lu_hold_inst got=%h exp=01095021", de_inst); end
    ex_dest = 5'd9; #1;
    checks++; if (de_stall_req !== 1'b1) begin errors++; $display("FAIL lu_rt got=%h exp=1", de_stall_req); end
    ex_dest = 5'd10; #1;
    checks++; if (de_stall_req !== 1'b0) begin errors++; $display("FAIL lu_rd got=%h exp=0", de_stall_req); end
    ex_dest = 5'd8; ex_is_load = 1'b0; #1;
    checks++; if (de_stall_req !== 1'b0) begin errors++; $display("FAIL lu_noload got=%h exp=0", de_stall_req); end
    step();
    checks++; if (de_pc !== 32'h3004) begin errors++; $display("FAIL lu_adv_pc got=%h exp=00003004", de_pc); end
    // branch held by hazard, resolves once hazard clears
    rs_value = 32'h9; rt_value = 32'h9;
    ex_is_load = 1'b1; ex_dest = 5'd9;
    fe_pc = 32'h3008; inst_sram_rdata = 32'h0; #1;
    checks++; if (de_br_taken !== 1'b0) begin errors++; $display("FAIL lu_br_taken got=%h exp=0", de_br_taken); end
    checks++; if (nextpc !== 32'h300c) begin errors++; $display("FAIL lu_br_nextpc got=%h exp=0000300c", nextpc); end
    step();
    ex_is_load = 1'b0; #1;
    checks++; if (nextpc !== 32'h3014) begin errors++; $display("FAIL lu_br_resolve got=%h exp=00003014", nextpc); end
    ex_is_load = 1'b1; flush = 1'b1;
    step();
    flush = 1'b0;
    checks++; if (de_valid !== 1'b0) begin errors++; $display("FAIL lu_flush_valid got=%h exp=0", de_valid); end
    checks++; if (de_stall_req !== 1'b0) begin errors++; $display("FAIL lu_flush_stallreq got=%h exp=0", de_stall_req); end
    ex_is_load = 1'b0; ex_dest = 5'd0;
  endtask

  task automatic test_stall;
    load(32'h7000, 32'h24A00010);
    stall = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      load(32'h7000 + 32'(i * 4), 32'h1000 + 32'(i));
      checks++; if (de_pc !== 32'h7000 || de_inst !== 32'h24A00010 || de_valid !== 1'b1) begin errors++; $display("FAIL stall_hold[%0d] got=%h/%h/%h exp=00007000/24a00010/1", i, de_pc, de_inst, de_valid); end
    end
    stall = 1'b0;
    step();
    checks++; if (de_pc !== 32'h700c) begin errors++; $display("FAIL stall_release got=%h exp=0000700c", de_pc); end
    de_en = 1'b0;
    load(32'h7010, 32'h0);
    checks++; if (de_pc !== 32'h700c) begin errors++; $display("FAIL en_hold got=%h exp=0000700c", de_pc); end
    de_en = 1'b1;
    stall = 1'b1; resetn = 1'b0;
    step();
    checks++; if (de_valid !== 1'b0 || de_pc !== 32'hbfc00000 || de_inst !== 32'h0) begin errors++; $display("FAIL rst_mid_stall got=%h/%h/%h exp=0/bfc00000/0", de_valid, de_pc, de_inst); end
    resetn = 1'b1; stall = 1'b0;
  endtask

  initial begin
    test_reset();
    test_first_fetch();
    test_beq();
    test_bne();
    test_conditions();
    test_jumps();
    test_jr_flush();
    test_load_use();
    test_stall();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
